// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the RV32 pipeline datapath and the stall/flush sequencer.
// The datapath uses the master side; the sequencer uses the slave side.
interface pipeline_hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       Rs1D;
   logic [4:0]       Rs2D;
   logic [4:0]       RdE;
   logic             RegWriteE;
   logic             LoadE;
   logic             MispredictE;
   logic             McStartE;
   logic             McDoneE;
   logic             IMemReadyF;
   logic             MemAccessM;
   logic             DMemReadyM;
   logic             StallF;
   logic             StallD;
   logic             FlushD;
   logic             StallE;
   logic             FlushE;
   logic             FlushM;
   logic             FlushW;
   logic             McBusy;
   logic             McErr;
   logic [CNT_W-1:0] StallCnt;
   logic [CNT_W-1:0] FlushCnt;

   modport master (
      output Rs1D, Rs2D, RdE, RegWriteE, LoadE, MispredictE, McStartE, McDoneE,
             IMemReadyF, MemAccessM, DMemReadyM,
      input  StallF, StallD, FlushD, StallE, FlushE, FlushM, FlushW,
             McBusy, McErr, StallCnt, FlushCnt
   );

   modport slave (
      input  Rs1D, Rs2D, RdE, RegWriteE, LoadE, MispredictE, McStartE, McDoneE,
             IMemReadyF, MemAccessM, DMemReadyM,
      output StallF, StallD, FlushD, StallE, FlushE, FlushM, FlushW,
             McBusy, McErr, StallCnt, FlushCnt
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline, with a small FSM for
// multi-cycle M/F-unit operations and saturating stall/flush counters.
//
// state   | meaning
// RUN     | normal issue; hazards resolved combinationally
// MC_BUSY | multi-cycle op in flight; pipeline held until done or timeout
module pipeline_hazard_ctrl #(
   parameter int MC_TIMEOUT = 64,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   pipeline_hazard_ctrl_if.slave bus
);
   typedef enum logic {
      RUN     = 1'b0,
      MC_BUSY = 1'b1
   } state_t;

   localparam int            TW       = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(MC_TIMEOUT - 1);

   state_t           r_state;
   state_t           w_next;
   logic [TW-1:0]    r_tmo_cnt;
   logic             r_mc_err;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   logic w_memstall;
   logic w_timeout;
   logic w_mcstall;
   logic w_lduse;
   logic w_ifstall;
   logic w_mp_flush;
   logic w_stall_f;
   logic w_stall_d;
   logic w_flush_d;
   logic w_stall_e;
   logic w_flush_e;
   logic w_flush_m;
   logic w_flush_w;

   assign w_memstall = bus.MemAccessM & ~bus.DMemReadyM;
   assign w_timeout  = (r_state == MC_BUSY) && (r_tmo_cnt == TMO_LAST);
   assign w_mcstall  = ((r_state == RUN) & bus.McStartE & ~bus.McDoneE) |
                       ((r_state == MC_BUSY) & ~bus.McDoneE & ~w_timeout);
   assign w_lduse    = bus.LoadE & bus.RegWriteE & (bus.RdE != 5'd0) &
                       ((bus.RdE == bus.Rs1D) | (bus.RdE == bus.Rs2D));
   assign w_ifstall  = ~bus.IMemReadyF;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= RUN;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_stall_f  = 1'b0;
      w_stall_d  = 1'b0;
      w_flush_d  = 1'b0;
      w_stall_e  = 1'b0;
      w_flush_e  = 1'b0;
      w_flush_m  = 1'b0;
      w_flush_w  = 1'b0;
      w_mp_flush = 1'b0;

      // a memory stall freezes the FSM so a pending mispredict or MC op is re-seen afterwards
      if (!w_memstall) begin
         case (r_state)
            RUN:     if (bus.McStartE && !bus.McDoneE) w_next = MC_BUSY;
            MC_BUSY: if (bus.McDoneE || w_timeout)     w_next = RUN;
            default: w_next = RUN;
         endcase
      end

      if (rst) begin
         w_next    = RUN;
         w_flush_d = 1'b1;
         w_flush_e = 1'b1;
         w_flush_m = 1'b1;
         w_flush_w = 1'b1;
      end else if (w_memstall) begin
         w_stall_f = 1'b1;
         w_stall_d = 1'b1;
         w_stall_e = 1'b1;
         w_flush_w = 1'b1;
      end else if (w_mcstall) begin
         w_stall_f = 1'b1;
         w_stall_d = 1'b1;
         w_stall_e = 1'b1;
         w_flush_m = 1'b1;
      end else if (bus.MispredictE) begin
         w_flush_d  = 1'b1;
         w_flush_e  = 1'b1;
         w_mp_flush = 1'b1;
      end else if (w_lduse) begin
         // holding D also covers a concurrent fetch miss: the stalled instruction stays put
         w_stall_f = 1'b1;
         w_stall_d = 1'b1;
         w_flush_e = 1'b1;
      end else if (w_ifstall) begin
         w_stall_f = 1'b1;
         w_flush_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tmo_cnt <= '0;
         r_mc_err  <= 1'b0;
      end else if (!w_memstall) begin
         if (r_state == RUN) begin
            r_tmo_cnt <= '0;
         end else begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
            if (w_timeout && !bus.McDoneE) r_mc_err <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall_f && (r_stall_cnt != '1))  r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_mp_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign bus.StallF   = w_stall_f;
   assign bus.StallD   = w_stall_d;
   assign bus.FlushD   = w_flush_d;
   assign bus.StallE   = w_stall_e;
   assign bus.FlushE   = w_flush_e;
   assign bus.FlushM   = w_flush_m;
   assign bus.FlushW   = w_flush_w;
   assign bus.McBusy   = ~rst & (r_state == MC_BUSY);
   assign bus.McErr    = r_mc_err;
   assign bus.StallCnt = r_stall_cnt;
   assign bus.FlushCnt = r_flush_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a default instance plus an
// MC_TIMEOUT=8 instance sharing the same input stimulus.
module tb_pipeline_hazard_ctrl;
   logic clk;
   logic rst;
   int   vec;
   int   errs;

   pipeline_hazard_ctrl_if #(.CNT_W(32)) hif ();
   pipeline_hazard_ctrl_if #(.CNT_W(32)) hif8 ();

   pipeline_hazard_ctrl #(.MC_TIMEOUT(64), .CNT_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (hif.slave)
   );

   pipeline_hazard_ctrl #(.MC_TIMEOUT(8), .CNT_W(32)) dut8 (
      .clk (clk),
      .rst (rst),
      .bus (hif8.slave)
   );

   assign hif8.Rs1D        = hif.Rs1D;
   assign hif8.Rs2D        = hif.Rs2D;
   assign hif8.RdE         = hif.RdE;
   assign hif8.RegWriteE   = hif.RegWriteE;
   assign hif8.LoadE       = hif.LoadE;
   assign hif8.MispredictE = hif.MispredictE;
   assign hif8.McStartE    = hif.McStartE;
   assign hif8.McDoneE     = hif.McDoneE;
   assign hif8.IMemReadyF  = hif.IMemReadyF;
   assign hif8.MemAccessM  = hif.MemAccessM;
   assign hif8.DMemReadyM  = hif.DMemReadyM;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // outputs packed as {StallF,StallD,FlushD,StallE,FlushE,FlushM,FlushW}
   function automatic logic [6:0] ctl();
      return {hif.StallF, hif.StallD, hif.FlushD, hif.StallE,
              hif.FlushE, hif.FlushM, hif.FlushW};
   endfunction

   task automatic idle();
      hif.Rs1D        = 5'd0;
      hif.Rs2D        = 5'd0;
      hif.RdE         = 5'd0;
      hif.RegWriteE   = 1'b0;
      hif.LoadE       = 1'b0;
      hif.MispredictE = 1'b0;
      hif.McStartE    = 1'b0;
      hif.McDoneE     = 1'b0;
      hif.IMemReadyF  = 1'b1;
      hif.MemAccessM  = 1'b0;
      hif.DMemReadyM  = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      vec++;
      if (ctl() !== 7'b0000000 || hif.McBusy !== 1'b0 || hif.McErr !== 1'b0) begin
         errs++;
         $display("FAIL reset_idle: ctl=%b busy=%b err=%b, required ctl=0000000 busy=0 err=0",
                  ctl(), hif.McBusy, hif.McErr);
      end
      // enter MC_BUSY, then reset mid-run
      step();
      hif.McStartE = 1'b1;
      step();
      hif.McStartE = 1'b0;
      #1;
      vec++;
      if (hif.McBusy !== 1'b1) begin
         errs++;
         $display("FAIL reset_pre_busy: McBusy=%b, required 1", hif.McBusy);
      end
      rst = 1'b1;
      #1;
      vec++;
      if (ctl() !== 7'b0010111 || hif.McBusy !== 1'b0 || hif.StallCnt !== 32'd0) begin
         errs++;
         $display("FAIL reset_midrun: ctl=%b busy=%b stallcnt=%0d, required ctl=0010111 busy=0 cnt=0",
                  ctl(), hif.McBusy, hif.StallCnt);
      end
      step();
      rst = 1'b0;
      @(negedge clk);
      vec++;
      if (hif.McBusy !== 1'b0 || ctl() !== 7'b0000000) begin
         errs++;
         $display("FAIL reset_release: busy=%b ctl=%b, required busy=0 ctl=0000000",
                  hif.McBusy, ctl());
      end
   endtask

   task automatic test_load_use();
      do_reset();
      hif.LoadE = 1'b1; hif.RegWriteE = 1'b1; hif.RdE = 5'd5; hif.Rs1D = 5'd5; hif.Rs2D = 5'd7;
      @(negedge clk);
      vec++;
      if (ctl() !== 7'b1100100) begin
         errs++;
         $display("FAIL lduse_bubble: ctl=%b, required 1100100", ctl());
      end
      step();
      idle();
      @(negedge clk);
      vec++;
      if (ctl() !== 7'b0000000) begin
         errs++;
         $display("FAIL lduse_release: ctl=%b, required 0000000", ctl());
      end
      step();
      hif.LoadE = 1'b1; hif.RegWriteE = 1'b1; hif.RdE = 5'd9; hif.Rs1D = 5'd1; hif.Rs2D = 5'd9;
      @(negedge clk);
      vec++;
      if (ctl() !== 7'b1100100) begin
         errs++;
         $display("FAIL lduse_rs2: ctl=%b, required 1100100", ctl());
      end
      step();
      hif.RdE = 5'd0; hif.Rs1D = 5'd0; hif.Rs2D = 5'd0;
      @(negedge clk);
      vec++;
      if (ctl() !== 7'b0000000) begin
         errs++;
         $display("FAIL lduse_x0: ctl=%b, required 0000000", ctl());
      end
      step();
      idle();
      step();
      vec++;
      if (hif.StallCnt !== 32'd2) begin
         errs++;
         $display("FAIL lduse_stallcnt: got %0d, required 2", hif.StallCnt);
      end
   endtask

   task automatic test_multicycle();
      int stalls;
      int busys;
      do_reset();
      stalls = 0;
      busys  = 0;
      hif.McStartE = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (ctl() === 7'b1101010) stalls++;
         if (hif.McBusy === 1'b1) busys++;
         step();
         hif.McStartE = 1'b0;
      end
      vec++;
      if (stalls !== 10 || busys !== 9) begin
         errs++;
         $display("FAIL mc_div_hold: stall cycles=%0d busy cycles=%0d, required 10 and 9",
                  stalls, busys);
      end
      hif.McDoneE = 1'b1;
      @(negedge clk);
      vec++;
      if (ctl() !== 7'b0000000) begin
         errs++;
         $display("FAIL mc_div_release: ctl=%b, required 0000000", ctl());
      end
      step();
      hif.McDoneE = 1'b0;
      @(negedge clk);
      vec++;
      if (hif.McBusy !== 1'b0 || hif.StallCnt !== 32'd10) begin
         errs++;
         $display("FAIL mc_div_after: busy=%b stallcnt=%0d, required busy=0 cnt=10",
                  hif.McBusy, hif.StallCnt);
      end
      step();
      hif.McStartE = 1'b1;
      hif.McDoneE  = 1'b1;
      @(negedge clk);
      vec++;
      if (ctl() !== 7'b0000000) begin
         errs++;
         $display("FAIL mc_zero_lat: ctl=%b, required 0000000", ctl());
      end
      step();
      idle();
      @(negedge clk);
      vec++;
      if (hif.McBusy !== 1'b0 || hif.StallCnt !== 32'd10) begin
         errs++;
         $display("FAIL mc_zero_lat_after: busy=%b stallcnt=%0d, required busy=0 cnt=10",
                  hif.McBusy, hif.StallCnt);
      end
   endtask

   task automatic test_timeout();
      int busys;
      int stalls;
      do_reset();
      busys  = 0;
      stalls = 0;
      vec++;
      if (hif8.McErr !== 1'b0) begin
         errs++;
         $display("FAIL tmo_err_init: McErr=%b, required 0", hif8.McErr);
      end
      hif.McStartE = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (hif8.McBusy === 1'b1) busys++;
         if (hif8.StallF === 1'b1) stalls++;
         step();
         hif.McStartE = 1'b0;
      end
      vec++;
      if (busys !== 8 || stalls !== 8) begin
         errs++;
         $display("FAIL tmo_busy_cycles: busy=%0d stalled=%0d, required 8 and 8", busys, stalls);
      end
      vec++;
      if (hif8.McErr !== 1'b1 || hif8.McBusy !== 1'b0) begin
         errs++;
         $display("FAIL tmo_err_set: McErr=%b McBusy=%b, required 1 and 0",
                  hif8.McErr, hif8.McBusy);
      end
      vec++;
      if (hif.McErr !== 1'b0) begin
         errs++;
         $display("FAIL tmo_default_inst: McErr=%b, required 0", hif.McErr);
      end
   endtask

   task automatic test_mispredict_memstall();
      int held;
      do_reset();
      held = 0;
      hif.MispredictE = 1'b1;
      hif.MemAccessM  = 1'b1;
      hif.DMemReadyM  = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (ctl() === 7'b1101001) held++;
         step();
      end
      vec++;
      if (held !== 3) begin
         errs++;
         $display("FAIL mp_memstall_hold: matching cycles=%0d, required 3", held);
      end
      hif.DMemReadyM = 1'b1;
      @(negedge clk);
      vec++;
      if (ctl() !== 7'b0010100) begin
         errs++;
         $display("FAIL mp_flush: ctl=%b, required 0010100", ctl());
      end
      step();
      idle();
      @(negedge clk);
      vec++;
      if (hif.FlushCnt !== 32'd1 || hif.StallCnt !== 32'd3) begin
         errs++;
         $display("FAIL mp_counts: flushcnt=%0d stallcnt=%0d, required 1 and 3",
                  hif.FlushCnt, hif.StallCnt);
      end
   endtask

   task automatic test_fetch_lduse();
      do_reset();
      hif.IMemReadyF = 1'b0;
      hif.LoadE = 1'b1; hif.RegWriteE = 1'b1; hif.RdE = 5'd12; hif.Rs1D = 5'd12;
      @(negedge clk);
      vec++;
      if (ctl() !== 7'b1100100) begin
         errs++;
         $display("FAIL ifmiss_lduse_c1: ctl=%b, required 1100100", ctl());
      end
      step();
      hif.LoadE = 1'b0; hif.RegWriteE = 1'b0; hif.RdE = 5'd0; hif.Rs1D = 5'd0;
      @(negedge clk);
      vec++;
      if (ctl() !== 7'b1010000) begin
         errs++;
         $display("FAIL ifmiss_c2: ctl=%b, required 1010000", ctl());
      end
      step();
      idle();
      @(negedge clk);
      vec++;
      if (ctl() !== 7'b0000000 || hif.StallCnt !== 32'd2) begin
         errs++;
         $display("FAIL ifmiss_after: ctl=%b stallcnt=%0d, required 0000000 and 2",
                  ctl(), hif.StallCnt);
      end
   endtask

   initial begin
      vec  = 0;
      errs = 0;
      rst  = 1'b1;
      idle();
      test_reset();
      test_load_use();
      test_multicycle();
      test_timeout();
      test_mispredict_memstall();
      test_fetch_lduse();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV32 pipeline. It drives StallF, StallD, FlushD (IF/ID register) and StallE, FlushE, FlushM, FlushW (downstream registers). It resolves load-use hazards, branch mispredicts, instruction/data memory wait states and multi-cycle M/F-unit operations through a small FSM. It also keeps stall/flush performance counters.

Parameters:
MC_TIMEOUT, 64, max cycles in MC_BUSY before forced abort
CNT_W, 32, width of performance counters

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
Rs1D  in  5  source reg 1 of instruction in Decode
Rs2D  in  5  source reg 2 of instruction in Decode
RdE  in  5  destination reg of instruction in Execute
RegWriteE  in  1  Execute instruction writes RF
LoadE  in  1  Execute instruction is a load
MispredictE  in  1  branch/jump resolved in E disagrees with TakenD prediction
McStartE  in  1  valid multi-cycle op (div/rem/FP) in E, first cycle only
McDoneE  in  1  multi-cycle unit result valid (1-cycle pulse)
IMemReadyF  in  1  instruction memory returns valid word this cycle
MemAccessM  in  1  M-stage instruction accesses data memory
DMemReadyM  in  1  data memory completes access this cycle
StallF  out  1  hold PC
StallD  out  1  hold IF/ID register
FlushD  out  1  clear IF/ID register (bubble, TakenD=0)
StallE  out  1  hold ID/EX register
FlushE  out  1  clear ID/EX register
FlushM  out  1  clear EX/MEM register
FlushW  out  1  clear MEM/WB register
McBusy  out  1  FSM in MC_BUSY
McErr  out  1  sticky timeout flag; cleared only by rst
StallCnt  out  CNT_W  cycles with StallF=1
FlushCnt  out  CNT_W  cycles with FlushD=1 caused by MispredictE

Behaviour:
- State register and counters reset asynchronously. Outputs are combinational from state and inputs.
- While rst=1: FlushD=FlushE=FlushM=FlushW=1, all stalls 0, McBusy=0, McErr=0, counters 0, state RUN.
- FSM states: RUN, MC_BUSY.
  - RUN -> MC_BUSY: McStartE=1, McDoneE=0, and no memory stall.
  - MC_BUSY -> RUN: McDoneE=1, or timeout counter reaches MC_TIMEOUT-1. On timeout, set McErr=1.
  - The timeout counter clears on entry to MC_BUSY and increments each MC_BUSY cycle. It freezes during a memory stall.
- Condition terms:
  - memstall = MemAccessM & ~DMemReadyM
  - mcstall = (RUN & McStartE & ~McDoneE) | (MC_BUSY & ~McDoneE & ~timeout)
  - lduse = LoadE & RegWriteE & (RdE!=0) & ((RdE==Rs1D)|(RdE==Rs2D))
  - ifstall = ~IMemReadyF
- Priority, highest first:
  1. memstall: StallF=StallD=StallE=1, FlushW=1. All other flushes are 0, including when MispredictE=1; the mispredict is re-evaluated after the stall. The FSM holds state.
  2. mcstall: StallF=StallD=StallE=1, FlushM=1. MispredictE cannot coincide (same stage); if it does, ignore it.
  3. MispredictE: FlushD=FlushE=1, stalls 0. This overrides lduse and ifstall.
  4. lduse: StallF=StallD=1, FlushE=1. This is exactly 1 bubble, since the load advances the next cycle.
  5. ifstall: StallF=1, FlushD=1 (bubble into Decode), StallD=0.
- lduse and ifstall together: StallF=StallD=1, FlushE=1, FlushD=0. The held instruction stays in D.
- StallD=1 and FlushD=1 never assert together.
- Counters saturate at all-ones; no wrap-around.
- StallCnt increments on every cycle with StallF=1.
- FlushCnt increments only when priority 3 is active.

Test Plan:
- Reset mid-run: assert rst with state=MC_BUSY -> outputs: Flush* = 1, stalls 0, McBusy=0, StallCnt=0, state RUN after release.
- Load-use, single bubble:
  - Setup: LoadE=1, RegWriteE=1, RdE=5, Rs1D=5, one cycle.
  - Required: StallF=StallD=FlushE=1 for exactly 1 cycle.
  - Negative check: RdE=0 gives no stall.
- Multi-cycle divide:
  - Setup: McStartE pulse, McDoneE after 10 cycles.
  - Required: StallF/StallD/StallE=1 and FlushM=1 for 10 cycles, McBusy=1 for 9 cycles, released on the McDoneE cycle, StallCnt=10.
  - Zero-latency case: McStartE and McDoneE together -> no stall.
- Timeout:
  - Setup: MC_TIMEOUT=8, McDoneE never asserted.
  - Required: FSM returns to RUN after 8 MC_BUSY cycles, McErr=1 and stays 1.
- Mispredict vs memory stall:
  - Setup: MispredictE=1 with MemAccessM=1, DMemReadyM=0 for 3 cycles, then ready.
  - Required: 3 cycles of full stall with FlushD=0, then FlushD=FlushE=1 for one cycle, FlushCnt=1.
- Fetch miss combined with load-use:
  - Setup: IMemReadyF=0 for 2 cycles, with lduse in the first.
  - Required: cycle 1 StallF=StallD=FlushE=1, FlushD=0; cycle 2 StallF=FlushD=1, StallD=0.
